// File: rtl/push_stack_pkg.sv
// Shared constants and op encoding for the operand stack and the ALU control decoder.
// Optional next-on-stack/swap support is selected elsewhere with PUSH_STACK_NOS_EN.
package push_stack_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 8;

  // Encoding is {push, pop}, so a concatenation of the two strobes casts directly.
  typedef enum logic [1:0] {
    OpNop     = 2'b00,
    OpPop     = 2'b01,
    OpPush    = 2'b10,
    OpReplace = 2'b11
  } op_e;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/push_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port plus combinational top read.
// With PUSH_STACK_NOS_EN it also reads next-on-stack and can exchange the top two entries.
module push_stack_mem
  import push_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    top_idx_i,
`ifdef PUSH_STACK_NOS_EN
  input  logic             swap_i,
  output logic [WIDTH-1:0] nos_o,
`endif
  output logic [WIDTH-1:0] top_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

`ifdef PUSH_STACK_NOS_EN
  logic [AW-1:0] nos_idx;
  assign nos_idx = top_idx_i - AW'(1);
  assign nos_o   = mem_q[nos_idx];

  // A write and a swap are never requested together; the write wins if they were.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else if (swap_i) begin
      mem_q[top_idx_i] <= mem_q[nos_idx];
      mem_q[nos_idx]   <= mem_q[top_idx_i];
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`endif

  assign top_o = mem_q[top_idx_i];

endmodule

// File: rtl/push_stack.sv
// LIFO operand stack with occupancy, full/empty status and sticky overflow/underflow flags.
// Define PUSH_STACK_NOS_EN to add the NOS output and SWAP input.
module push_stack
  import push_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CW    = count_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
`ifdef PUSH_STACK_NOS_EN
  input  logic             swap_i,
  output logic [WIDTH-1:0] nos_o,
`endif
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int unsigned AW = addr_width(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_rd;
  logic             empty, full;
  op_e              op;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // Garbage when empty; every consumer is gated by empty.
  assign top_idx = AW'(count_q - CW'(1));
  assign op      = op_e'({push_i, pop_i});

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = top_idx;
    unique case (op)
      OpPush: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = AW'(count_q);
          count_d = count_q + CW'(1);
        end
      end
      OpPop: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      OpReplace: begin
        we = 1'b1;
        // Replace on an empty stack degenerates to a plain push into slot 0.
        if (empty) begin
          waddr   = '0;
          count_d = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef PUSH_STACK_NOS_EN
  logic             swap_en;
  logic [WIDTH-1:0] nos_rd;

  assign swap_en = swap_i && (op == OpNop) && (count_q >= CW'(2)) && !rst_i;
  assign nos_o   = (count_q >= CW'(2)) ? nos_rd : '0;
`endif

  push_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .we_i      (we && !rst_i),
    .waddr_i   (waddr),
    .wdata_i   (din_i),
    .top_idx_i (top_idx),
`ifdef PUSH_STACK_NOS_EN
    .swap_i    (swap_en),
    .nos_o     (nos_rd),
`endif
    .top_o     (top_rd)
  );

  assign dout_o  = empty ? '0 : top_rd;
  assign empty_o = empty;
  assign full_o  = full;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule
